// File: rtl/fifo_flow_ctrl_pkg.sv
// Shared definitions for the FIFO flow controller: default geometry, idle-mode
// encoding, handshake FSM states and the per-mode grant thresholds.
package fifo_flow_ctrl_pkg;

    localparam int unsigned ADDRSIZE  = 10;
    localparam int unsigned DEPTH     = 2 ** ADDRSIZE;
    localparam int unsigned NUM_MODES = 6;

    // mode = {widle, ridle}; codes 6 and 7 are illegal
    typedef enum logic [2:0] {
        MODE_0 = 3'd0,
        MODE_1 = 3'd1,
        MODE_2 = 3'd2,
        MODE_3 = 3'd3,
        MODE_4 = 3'd4,
        MODE_5 = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_W_ACK,
        ST_R_ACK,
        ST_RELEASE
    } state_e;

    typedef int unsigned thresh_t [NUM_MODES];

    // Minimum free entries to grant a write / used entries to grant a read
    localparam thresh_t WR_THRESH_DEF = '{560, 792, 95, 560, 1, 327};
    localparam thresh_t RD_THRESH_DEF = '{1, 1, 1, 1, 274, 1};

    function automatic logic mode_legal(input logic [2:0] m);
        return m <= 3'(MODE_5);
    endfunction

endpackage

// File: rtl/fifo_flow_ctrl_occupancy.sv
// FIFO occupancy: modular pointer subtract, registered used/free counts and
// full/empty flags (one cycle behind the pointers).
// Ports: clk, rst (sync, active-high), wptr_i/rptr_i binary pointers with wrap
// MSB, used_cnt_o/free_cnt_o counts, wfull_o/rempty_o flags.
module fifo_occupancy #(
    parameter int unsigned ADDRSIZE = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDRSIZE:0]   wptr_i,
    input  logic [ADDRSIZE:0]   rptr_i,
    output logic [ADDRSIZE:0]   used_cnt_o,
    output logic [ADDRSIZE:0]   free_cnt_o,
    output logic                wfull_o,
    output logic                rempty_o
);
    import fifo_flow_ctrl_pkg::*;

    localparam int unsigned      CNT_W    = ADDRSIZE + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(2 ** ADDRSIZE);

    logic [CNT_W-1:0] used_raw;
    logic [CNT_W-1:0] used_d;
    logic [CNT_W-1:0] used_q;
    logic [CNT_W-1:0] free_q;
    logic             wfull_q;
    logic             rempty_q;

    // Subtract at pointer width so wrap falls out of the modulus
    assign used_raw = wptr_i - rptr_i;
    assign used_d   = (used_raw > FULL_CNT) ? FULL_CNT : used_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            used_q   <= '0;
            free_q   <= FULL_CNT;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
        end else begin
            used_q   <= used_d;
            free_q   <= FULL_CNT - used_d;
            wfull_q  <= (used_d == FULL_CNT);
            rempty_q <= (used_d == '0);
        end
    end

    // Pointers more than DEPTH apart indicate broken upstream pointer logic
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (used_raw <= FULL_CNT);
        end
    end

    assign used_cnt_o = used_q;
    assign free_cnt_o = free_q;
    assign wfull_o    = wfull_q;
    assign rempty_o   = rempty_q;

endmodule

// File: rtl/fifo_flow_ctrl.sv
// FIFO flow controller: grants producer writes and consumer reads through a
// four-phase req/ack handshake against per-idle-mode thresholds, with
// alternating priority on contention and an ack-hold watchdog.
// Ports: clk, rst (sync, active-high), wptr/rptr pointers, wreq/rreq requests,
// widle/ridle idle codes, wack/rack acks, wfull/rempty flags, used_cnt/free_cnt
// counts, mode_err/timeout_err one-cycle error pulses.
module fifo_flow_ctrl #(
    parameter int unsigned                 ADDRSIZE  = fifo_flow_ctrl_pkg::ADDRSIZE,
    parameter int unsigned                 TIMEOUT   = 64,
    parameter fifo_flow_ctrl_pkg::thresh_t WR_THRESH = fifo_flow_ctrl_pkg::WR_THRESH_DEF,
    parameter fifo_flow_ctrl_pkg::thresh_t RD_THRESH = fifo_flow_ctrl_pkg::RD_THRESH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic                wreq,
    input  logic                rreq,
    input  logic [1:0]          widle,
    input  logic                ridle,
    output logic                wack,
    output logic                rack,
    output logic                wfull,
    output logic                rempty,
    output logic [ADDRSIZE:0]   used_cnt,
    output logic [ADDRSIZE:0]   free_cnt,
    output logic                mode_err,
    output logic                timeout_err
);
    import fifo_flow_ctrl_pkg::*;

    localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [ADDRSIZE:0] used_w;
    logic [ADDRSIZE:0] free_w;
    logic              wfull_w;
    logic              rempty_w;

    fifo_occupancy #(.ADDRSIZE(ADDRSIZE)) u_occ (
        .clk        (clk),
        .rst        (rst),
        .wptr_i     (wptr),
        .rptr_i     (rptr),
        .used_cnt_o (used_w),
        .free_cnt_o (free_w),
        .wfull_o    (wfull_w),
        .rempty_o   (rempty_w)
    );

    logic [2:0]  mode_c;
    logic        mode_ok_c;
    logic [31:0] wr_thr_c;
    logic [31:0] rd_thr_c;
    logic        wok_c;
    logic        rok_c;
    logic        held_req_c;

    state_e         state_q;
    logic           wack_q;
    logic           rack_q;
    logic           prio_w_q;
    logic           owner_w_q;
    logic [WDW-1:0] wdog_q;
    logic           mode_err_q;
    logic           timeout_err_q;

    assign mode_c    = {widle, ridle};
    assign mode_ok_c = mode_legal(mode_c);

    // Threshold lookup; illegal modes never reach a grant decision
    always_comb begin
        wr_thr_c = '0;
        rd_thr_c = '0;
        for (int unsigned i = 0; i < NUM_MODES; i++) begin
            if (mode_c == 3'(i)) begin
                wr_thr_c = WR_THRESH[i];
                rd_thr_c = RD_THRESH[i];
            end
        end
    end

    assign wok_c      = (32'(free_w) >= wr_thr_c) && !wfull_w;
    assign rok_c      = (32'(used_w) >= rd_thr_c) && !rempty_w;
    assign held_req_c = owner_w_q ? wreq : rreq;

    // Handshake FSM with registered acks and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wack_q        <= 1'b0;
            rack_q        <= 1'b0;
            prio_w_q      <= 1'b1;
            owner_w_q     <= 1'b0;
            wdog_q        <= '0;
            mode_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            mode_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if ((wreq || rreq) && !mode_ok_c) begin
                        mode_err_q <= 1'b1;
                    end else if (wreq && wok_c && (!(rreq && rok_c) || prio_w_q)) begin
                        state_q   <= ST_W_ACK;
                        wack_q    <= 1'b1;
                        owner_w_q <= 1'b1;
                        wdog_q    <= '0;
                        if (rreq && rok_c) begin
                            prio_w_q <= 1'b0;
                        end
                    end else if (rreq && rok_c) begin
                        state_q   <= ST_R_ACK;
                        rack_q    <= 1'b1;
                        owner_w_q <= 1'b0;
                        wdog_q    <= '0;
                        if (wreq && wok_c) begin
                            prio_w_q <= 1'b1;
                        end
                    end
                end
                ST_W_ACK, ST_R_ACK: begin
                    if (!held_req_c) begin
                        wack_q  <= 1'b0;
                        rack_q  <= 1'b0;
                        state_q <= ST_RELEASE;
                    end else if ((TIMEOUT != 0) && (wdog_q == WDW'(TIMEOUT - 1))) begin
                        wack_q        <= 1'b0;
                        rack_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_RELEASE;
                    end else begin
                        wdog_q <= wdog_q + WDW'(1);
                    end
                end
                ST_RELEASE: begin
                    // Wait out a timed-out requester still holding req high
                    if (!held_req_c) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wack        = wack_q;
    assign rack        = rack_q;
    assign wfull       = wfull_w;
    assign rempty      = rempty_w;
    assign used_cnt    = used_w;
    assign free_cnt    = free_w;
    assign mode_err    = mode_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Self-checking bench for fifo_flow_ctrl: vector table, directed handshake
// corner sequences and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_fifo_flow_ctrl;

    localparam int DEPTH = 1024;
    localparam int PMOD  = 2048;
    localparam int TMO   = 64;
    localparam int WT[6] = '{560, 792, 95, 560, 1, 327};
    localparam int RT[6] = '{1, 1, 1, 1, 274, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] wptr, rptr;
    logic        wreq, rreq;
    logic [1:0]  widle;
    logic        ridle;
    logic        wack, rack, wfull, rempty, mode_err, timeout_err;
    logic [10:0] used_cnt, free_cnt;

    fifo_flow_ctrl #(.ADDRSIZE(10), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .wptr        (wptr),
        .rptr        (rptr),
        .wreq        (wreq),
        .rreq        (rreq),
        .widle       (widle),
        .ridle       (ridle),
        .wack        (wack),
        .rack        (rack),
        .wfull       (wfull),
        .rempty      (rempty),
        .used_cnt    (used_cnt),
        .free_cnt    (free_cnt),
        .mode_err    (mode_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int w; int r; int mode; int wq; int rq;
        int e_wack; int e_rack; int e_full; int e_empty; int e_used;
    } vec_t;
    vec_t vecs[$];

    // Behavioural model: grant phase 0 none, 1 ack held, 2 waiting for req low
    int m_phase, m_own_w, m_held, m_prio_w, m_used, m_merr, m_terr;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int w, input int r, input int mode);
        wptr = 11'(w);
        rptr = 11'(r);
        {widle, ridle} = 3'(mode);
    endtask

    task automatic do_reset();
        rst = 1'b1; wreq = 1'b0; rreq = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic model_step(input int r_rst, input int w, input int r, input int mode,
                              input int wq, input int rq);
        int free_now, full_now, empty_now, wg, rg, req_own;
        if (r_rst != 0) begin
            m_phase = 0; m_own_w = 0; m_held = 0; m_prio_w = 1;
            m_used = 0; m_merr = 0; m_terr = 0;
            return;
        end
        free_now  = DEPTH - m_used;
        full_now  = (m_used == DEPTH);
        empty_now = (m_used == 0);
        m_merr = 0; m_terr = 0;
        req_own = (m_own_w != 0) ? wq : rq;
        case (m_phase)
            0: begin
                if ((wq != 0 || rq != 0) && mode > 5) m_merr = 1;
                else if (mode <= 5) begin
                    wg = (wq != 0) && free_now >= WT[mode] && full_now == 0;
                    rg = (rq != 0) && m_used >= RT[mode] && empty_now == 0;
                    if (wg != 0 && rg != 0) begin
                        m_own_w = m_prio_w; m_prio_w = 1 - m_prio_w;
                    end else if (wg != 0) m_own_w = 1;
                    else if (rg != 0) m_own_w = 0;
                    if (wg != 0 || rg != 0) begin m_phase = 1; m_held = 1; end
                end
            end
            1: begin
                if (req_own == 0) m_phase = 2;
                else if (m_held == TMO) begin m_phase = 2; m_terr = 1; end
                else m_held++;
            end
            default: if (req_own == 0) m_phase = 0;
        endcase
        m_used = ((w - r) % PMOD + PMOD) % PMOD;
        if (m_used > DEPTH) m_used = DEPTH;
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int hi_cnt, terr_cnt, terr_idx, pend_w, pend_r;
        int w_i, r_i, mode_i, wq_i, rq_i, rst_i, u;
        int uses[6];
        logic [31:0] act_v, exp_v;

        // w, r, mode, wreq, rreq -> wack, rack, wfull, rempty, used
        vecs.push_back('{0,    0,    0, 0, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{100,  0,    0, 1, 0, 1, 0, 0, 0, 100});
        vecs.push_back('{1024, 0,    2, 1, 0, 0, 0, 1, 0, 1024});
        vecs.push_back('{1024, 1,    2, 1, 0, 0, 0, 0, 0, 1023});
        vecs.push_back('{1024, 200,  2, 1, 0, 1, 0, 0, 0, 824});
        vecs.push_back('{274,  0,    4, 0, 1, 0, 1, 0, 0, 274});
        vecs.push_back('{273,  0,    4, 0, 1, 0, 0, 0, 0, 273});
        vecs.push_back('{0,    1900, 0, 0, 1, 0, 1, 0, 0, 148});
        vecs.push_back('{700,  0,    5, 1, 0, 0, 0, 0, 0, 700});
        vecs.push_back('{200,  0,    1, 1, 0, 1, 0, 0, 0, 200});
        vecs.push_back('{465,  0,    3, 1, 0, 0, 0, 0, 0, 465});
        vecs.push_back('{464,  0,    3, 1, 0, 1, 0, 0, 0, 464});
        vecs.push_back('{500,  500,  0, 0, 1, 0, 0, 0, 1, 0});
        vecs.push_back('{100,  0,    6, 1, 0, 0, 0, 0, 0, 100});
        vecs.push_back('{1100, 76,   4, 0, 1, 0, 1, 1, 0, 1024});
        vecs.push_back('{2047, 2047, 4, 1, 0, 1, 0, 0, 1, 0});

        // Reset state
        drive(0, 0, 0);
        rst = 1'b1; wreq = 1'b0; rreq = 1'b0;
        cyc(3);
        check("rst_wack", wack, 0);
        check("rst_rack", rack, 0);
        check("rst_wfull", wfull, 0);
        check("rst_rempty", rempty, 1);
        check("rst_used", used_cnt, 0);
        check("rst_free", free_cnt, DEPTH);
        check("rst_mode_err", mode_err, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;
        cyc(2);

        // Vector table
        foreach (vecs[i]) begin
            wreq = 1'b0; rreq = 1'b0;
            drive(vecs[i].w, vecs[i].r, vecs[i].mode);
            cyc(2);
            wreq = vecs[i].wq[0]; rreq = vecs[i].rq[0];
            cyc(2);
            check($sformatf("vec%0d_wack", i), wack, vecs[i].e_wack);
            check($sformatf("vec%0d_rack", i), rack, vecs[i].e_rack);
            check($sformatf("vec%0d_wfull", i), wfull, vecs[i].e_full);
            check($sformatf("vec%0d_rempty", i), rempty, vecs[i].e_empty);
            check($sformatf("vec%0d_used", i), used_cnt, vecs[i].e_used);
            check($sformatf("vec%0d_free", i), free_cnt, DEPTH - vecs[i].e_used);
            wreq = 1'b0; rreq = 1'b0;
            cyc(4);
        end

        // Release sequence: ack falls one cycle after req, then a dead cycle
        drive(100, 0, 0);
        cyc(2);
        wreq = 1'b1; cyc(1); check("rel_grant", wack, 1);
        wreq = 1'b0; cyc(1); check("rel_drop", wack, 0);
        cyc(1);              check("rel_dead", wack, 0);
        wreq = 1'b1; cyc(1); check("rel_regrant", wack, 1);
        wreq = 1'b0; cyc(4);

        // Alternating priority on contention: W, R, W
        do_reset();
        drive(100, 0, 0);
        cyc(2);
        for (int k = 0; k < 3; k++) begin
            wreq = 1'b1; rreq = 1'b1;
            cyc(1);
            check($sformatf("alt%0d_wack", k), wack, (k % 2 == 0) ? 1 : 0);
            check($sformatf("alt%0d_rack", k), rack, (k % 2 == 0) ? 0 : 1);
            wreq = 1'b0; rreq = 1'b0;
            cyc(4);
        end

        // Illegal modes
        drive(100, 0, 6);
        cyc(2);              check("merr_no_req", mode_err, 0);
        wreq = 1'b1; cyc(1); check("merr6_pulse", mode_err, 1);
                             check("merr6_wack", wack, 0);
        wreq = 1'b0; cyc(1); check("merr6_clear", mode_err, 0);
        drive(100, 0, 7);
        rreq = 1'b1; cyc(1); check("merr7_pulse", mode_err, 1);
                             check("merr7_rack", rack, 0);
        rreq = 1'b0; cyc(1); check("merr7_clear", mode_err, 0);

        // Watchdog: req held past the limit
        do_reset();
        drive(100, 0, 0);
        cyc(2);
        wreq = 1'b1;
        hi_cnt = 0; terr_cnt = 0; terr_idx = -1;
        for (int i = 1; i <= 80; i++) begin
            cyc(1);
            if (wack) hi_cnt++;
            if (timeout_err) begin terr_cnt++; if (terr_idx < 0) terr_idx = i; end
        end
        check("to_ack_cycles", hi_cnt, TMO);
        check("to_err_count", terr_cnt, 1);
        check("to_err_cycle", terr_idx, TMO + 1);
        wreq = 1'b0; cyc(1); check("to_release", wack, 0);
        cyc(1);
        wreq = 1'b1; cyc(1); check("to_regrant", wack, 1);
        wreq = 1'b0; cyc(4);

        // Reset mid-handshake drops ack on the next edge
        wreq = 1'b1; cyc(1); check("rstmid_grant", wack, 1);
        rst = 1'b1;  cyc(1); check("rstmid_wack", wack, 0);
                             check("rstmid_used", used_cnt, 0);
        rst = 1'b0; wreq = 1'b0;
        cyc(3);

        // Randomized traffic against the model
        uses = '{0, 1, 273, 274, 1023, 1024};
        w_i = 0; r_i = 0; mode_i = 0; wq_i = 0; rq_i = 0;
        pend_w = 0; pend_r = 0;
        drive(w_i, r_i, mode_i);
        rst = 1'b1; wreq = 1'b0; rreq = 1'b0;
        model_step(1, w_i, r_i, mode_i, 0, 0);
        for (int c = 0; c < 1500; c++) begin
            cyc(1);
            exp_v = {16'(m_used), 1'(m_phase == 1 && m_own_w != 0), 1'(m_phase == 1 && m_own_w == 0),
                     1'(m_used == DEPTH), 1'(m_used == 0), 1'(m_merr), 1'(m_terr),
                     10'(0)};
            act_v = {5'(0), used_cnt, wack, rack, wfull, rempty, mode_err, timeout_err, 10'(0)};
            exp_v[31:16] = 16'(m_used);
            act_v[31:16] = 16'(used_cnt);
            n_checks++;
            if (act_v == exp_v && free_cnt == 11'(DEPTH - m_used)) n_pass++;
            else $display("FAIL rand_cycle%0d: got used=%0d free=%0d wack=%0d rack=%0d full=%0d empty=%0d merr=%0d terr=%0d expected used=%0d wack=%0d rack=%0d merr=%0d terr=%0d",
                          c, used_cnt, free_cnt, wack, rack, wfull, rempty, mode_err, timeout_err,
                          m_used, (m_phase == 1 && m_own_w != 0), (m_phase == 1 && m_own_w == 0), m_merr, m_terr);

            rst_i = ($urandom_range(0, 199) == 0) ? 1 : 0;
            if ($urandom_range(0, 7) == 0) begin
                r_i = int'($urandom_range(0, PMOD - 1));
                u = ($urandom_range(0, 1) == 0) ? uses[$urandom_range(0, 5)] : int'($urandom_range(0, DEPTH));
                w_i = (r_i + u) % PMOD;
            end
            if ($urandom_range(0, 15) == 0)
                mode_i = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
            if (wq_i == 0) wq_i = ($urandom_range(0, 3) == 0) ? 1 : 0;
            else if (wack) wq_i = ($urandom_range(0, 39) == 0) ? 0 : 1;
            else wq_i = ($urandom_range(0, 19) == 0) ? 0 : 1;
            if (rq_i == 0) rq_i = ($urandom_range(0, 3) == 0) ? 1 : 0;
            else if (rack) rq_i = ($urandom_range(0, 39) == 0) ? 0 : 1;
            else rq_i = ($urandom_range(0, 19) == 0) ? 0 : 1;
            pend_w += wq_i; pend_r += rq_i;
            rst = rst_i[0];
            drive(w_i, r_i, mode_i);
            wreq = wq_i[0]; rreq = rq_i[0];
            model_step(rst_i, w_i, r_i, mode_i, wq_i, rq_i);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
